// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX stage for the 32-bit ALU.
// Decodes RV32I, builds the immediates and picks the ALU operands. The result
// sits in a one-entry output buffer with valid/ready handshakes on both sides.
// Optional macro ILLEGAL_INSTR_TRAP_EN: illegal instructions are loaded and
// flagged on illegal_o instead of being dropped.
module id_ex_alu_issue #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instr_i,
  input  logic [D_WIDTH-1:0] pc_i,
  input  logic [D_WIDTH-1:0] rs1_data_i,
  input  logic [D_WIDTH-1:0] rs2_data_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [D_WIDTH-1:0] oprnd1_o,
  output logic [D_WIDTH-1:0] oprnd2_o,
  output logic [3:0]         alu_ctrl_o,
  output logic [4:0]         rd_addr_o,
  output logic               rd_wen_o,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic [2:0]         funct3_o,
`ifdef ILLEGAL_INSTR_TRAP_EN
  output logic               illegal_o,
`endif
  output logic [D_WIDTH-1:0] store_data_o
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Shared funct3 table for OP / OP-IMM; instr[30] only selects SUB for OP.
  function automatic logic [3:0] arith_alu(input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [D_WIDTH-1:0] imm_i, imm_s, imm_u, shamt_ext;
  logic unused_rs1_field;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign rd        = instr_i[11:7];
  assign imm_i     = {{(D_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s     = {{(D_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u     = {instr_i[31:12], 12'b0};
  assign shamt_ext = {{(D_WIDTH-5){1'b0}}, instr_i[24:20]};
  // rs1 index is resolved upstream by the register file read.
  assign unused_rs1_field = ^instr_i[19:15];

  logic [D_WIDTH-1:0] dec_oprnd1, dec_oprnd2;
  logic [3:0] dec_alu;
  logic dec_wen, dec_mem_rd, dec_mem_wr, dec_branch, dec_jump, dec_illegal;

  // Decode the incoming instruction into operands and control.
  always_comb begin
    dec_oprnd1  = '0;
    dec_oprnd2  = '0;
    dec_alu     = ALU_ADD;
    dec_wen     = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_oprnd1 = rs1_data_i;
        dec_oprnd2 = rs2_data_i;
        dec_alu    = arith_alu(funct3, instr_i[30], 1'b1);
        dec_wen    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_oprnd1 = rs1_data_i;
        dec_oprnd2 = (funct3[1:0] == 2'b01) ? shamt_ext : imm_i;
        dec_alu    = arith_alu(funct3, instr_i[30], 1'b0);
        dec_wen    = 1'b1;
      end
      OPC_LOAD: begin
        dec_oprnd1 = rs1_data_i;
        dec_oprnd2 = imm_i;
        dec_mem_rd = 1'b1;
        dec_wen    = 1'b1;
      end
      OPC_STORE: begin
        dec_oprnd1 = rs1_data_i;
        dec_oprnd2 = imm_s;
        dec_mem_wr = 1'b1;
      end
      OPC_BRANCH: begin
        dec_oprnd1 = rs1_data_i;
        dec_oprnd2 = rs2_data_i;
        dec_branch = 1'b1;
        case (funct3[2:1])
          2'b00:   dec_alu = ALU_SUB;
          2'b10:   dec_alu = ALU_SLT;
          2'b11:   dec_alu = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_oprnd2 = imm_u;
        dec_wen    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_oprnd1 = pc_i;
        dec_oprnd2 = imm_u;
        dec_wen    = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_oprnd1 = pc_i;
        dec_oprnd2 = D_WIDTH'(4);
        dec_jump   = 1'b1;
        dec_wen    = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal entry carries no side effects whatsoever.
    if (dec_illegal) begin
      dec_oprnd1 = '0;
      dec_oprnd2 = '0;
      dec_alu    = ALU_ADD;
      dec_wen    = 1'b0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
    end
    if (rd == 5'd0) dec_wen = 1'b0;
  end

  logic out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] oprnd1_q, oprnd1_d, oprnd2_q, oprnd2_d, store_data_q, store_data_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic [2:0] funct3_q, funct3_d;
  logic rd_wen_q, rd_wen_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic branch_q, branch_d, jump_q, jump_d;
  logic dec_loadable, load;
`ifdef ILLEGAL_INSTR_TRAP_EN
  logic illegal_q, illegal_d;
  assign dec_loadable = 1'b1;
`else
  assign dec_loadable = !dec_illegal;
`endif

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o && !flush_i && dec_loadable;

  // Next buffer state: flush wins, then load, else drain on transfer.
  always_comb begin
    out_valid_d  = flush_i ? 1'b0 : (load ? 1'b1 : (out_valid_q && !out_ready_i));
    oprnd1_d     = oprnd1_q;
    oprnd2_d     = oprnd2_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd_addr_d    = rd_addr_q;
    rd_wen_d     = rd_wen_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    funct3_d     = funct3_q;
    store_data_d = store_data_q;
`ifdef ILLEGAL_INSTR_TRAP_EN
    illegal_d    = illegal_q;
`endif
    if (load) begin
      oprnd1_d     = dec_oprnd1;
      oprnd2_d     = dec_oprnd2;
      alu_ctrl_d   = dec_alu;
      rd_addr_d    = rd;
      rd_wen_d     = dec_wen;
      mem_rd_d     = dec_mem_rd;
      mem_wr_d     = dec_mem_wr;
      branch_d     = dec_branch;
      jump_d       = dec_jump;
      funct3_d     = funct3;
      store_data_d = rs2_data_i;
`ifdef ILLEGAL_INSTR_TRAP_EN
      illegal_d    = dec_illegal;
`endif
    end
  end

  // Output buffer registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      oprnd1_q     <= '0;
      oprnd2_q     <= '0;
      alu_ctrl_q   <= '0;
      rd_addr_q    <= '0;
      rd_wen_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      funct3_q     <= '0;
      store_data_q <= '0;
`ifdef ILLEGAL_INSTR_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      oprnd1_q     <= oprnd1_d;
      oprnd2_q     <= oprnd2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd_addr_q    <= rd_addr_d;
      rd_wen_q     <= rd_wen_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      funct3_q     <= funct3_d;
      store_data_q <= store_data_d;
`ifdef ILLEGAL_INSTR_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  assign out_valid_o  = out_valid_q;
  assign oprnd1_o     = oprnd1_q;
  assign oprnd2_o     = oprnd2_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_wen_o     = rd_wen_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wr_o     = mem_wr_q;
  assign branch_o     = branch_q;
  assign jump_o       = jump_q;
  assign funct3_o     = funct3_q;
  assign store_data_o = store_data_q;
`ifdef ILLEGAL_INSTR_TRAP_EN
  assign illegal_o    = illegal_q;
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Testbench for id_ex_alu_issue: directed vectors, a behavioural model of the
// stage checked every cycle, and hand-computed literal checks.
// Honours ILLEGAL_INSTR_TRAP_EN the same way as the design.
module tb_id_ex_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] oprnd1_o, oprnd2_o, store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o, mem_rd_o, mem_wr_o, branch_o, jump_o;
  logic [2:0]  funct3_o;
  logic        dut_ill;
`ifdef ILLEGAL_INSTR_TRAP_EN
  logic        illegal_o;
  localparam bit TRAP = 1'b1;
  assign dut_ill = illegal_o;
`else
  localparam bit TRAP = 1'b0;
  assign dut_ill = 1'b0;
`endif

  id_ex_alu_issue #(.D_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .oprnd1_o(oprnd1_o), .oprnd2_o(oprnd2_o), .alu_ctrl_o(alu_ctrl_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .branch_o(branch_o), .jump_o(jump_o),
    .funct3_o(funct3_o),
`ifdef ILLEGAL_INSTR_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .store_data_o(store_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        wen, mrd, mwr, br, jmp;
    logic [2:0]  f3;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  // Reference decode straight from the instruction-set rules.
  // OP/OP-IMM codes are funct3 doubled, with the low bit marking SUB / SRA.
  function automatic exp_t model_decode(input logic [31:0] ins, pc, a, b);
    exp_t e;
    logic [2:0] f3;
    logic [31:0] imm_i, imm_s, imm_u;
    e = '0;
    f3 = ins[14:12];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u = {ins[31:12], 12'h000};
    e.rd = ins[11:7];
    e.f3 = f3;
    e.sd = b;
    case (ins[6:0])
      7'h33: begin
        e.op1 = a; e.op2 = b; e.wen = 1'b1;
        e.alu = {f3, ins[30] && (f3 == 3'd0 || f3 == 3'd5)};
      end
      7'h13: begin
        e.op1 = a; e.wen = 1'b1;
        e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm_i;
        e.alu = {f3, ins[30] && (f3 == 3'd5)};
      end
      7'h03: begin e.op1 = a; e.op2 = imm_i; e.mrd = 1'b1; e.wen = 1'b1; end
      7'h23: begin e.op1 = a; e.op2 = imm_s; e.mwr = 1'b1; end
      7'h63: begin
        e.op1 = a; e.op2 = b; e.br = 1'b1;
        if (f3 < 3'd2) e.alu = 4'd1;
        else if (f3 < 3'd4) e.ill = 1'b1;
        else if (f3 < 3'd6) e.alu = 4'd4;
        else e.alu = 4'd6;
      end
      7'h37: begin e.op2 = imm_u; e.wen = 1'b1; end
      7'h17: begin e.op1 = pc; e.op2 = imm_u; e.wen = 1'b1; end
      7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; e.jmp = 1'b1; e.wen = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.alu = '0; e.wen = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
    end
    if (e.rd == 5'd0) e.wen = 1'b0;
    return e;
  endfunction

  // Operands, rd, funct3 and store data carry no meaning for an illegal entry.
  function automatic exp_t mask_ill(input exp_t x, input logic ill);
    exp_t y;
    y = x;
    if (ill) begin y.op1 = '0; y.op2 = '0; y.rd = '0; y.f3 = '0; y.sd = '0; end
    return y;
  endfunction

  // Model of the one-entry buffer.
  logic m_valid;
  exp_t m_out;
  always @(posedge clk_i or posedge rst_i) begin : model
    exp_t d;
    logic rdy;
    if (rst_i) begin
      m_valid <= 1'b0;
      m_out   <= '0;
    end else begin
      d = model_decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
      rdy = !m_valid || out_ready_i;
      if (flush_i) m_valid <= 1'b0;
      else if (in_valid_i && rdy && (TRAP || !d.ill)) begin
        m_valid <= 1'b1;
        m_out   <= d;
      end else m_valid <= m_valid && !out_ready_i;
    end
  end

  exp_t dut_vec;
  always_comb begin
    dut_vec = {oprnd1_o, oprnd2_o, alu_ctrl_o, rd_addr_o, rd_wen_o, mem_rd_o,
               mem_wr_o, branch_o, jump_o, funct3_o, store_data_o, dut_ill};
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      checks++;
      if (out_valid_o !== m_valid) begin
        errors++;
        $display("FAIL cyc_out_valid: got %b expected %b at %0t", out_valid_o, m_valid, $time);
      end
      checks++;
      if (in_ready_o !== (!m_valid || out_ready_i)) begin
        errors++;
        $display("FAIL cyc_in_ready: got %b expected %b at %0t", in_ready_o,
                 !m_valid || out_ready_i, $time);
      end
      if (m_valid) begin
        checks++;
        if (mask_ill(dut_vec, m_out.ill) !== mask_ill(m_out, m_out.ill)) begin
          errors++;
          $display("FAIL cyc_outputs: got %h expected %h at %0t",
                   mask_ill(dut_vec, m_out.ill), mask_ill(m_out, m_out.ill), $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one instruction with out_ready_i=1 and wait until it is accepted.
  task automatic send(input logic [31:0] ins, pc, a, b, input string nm);
    logic acc;
    acc = 1'b0;
    instr_i = ins; pc_i = pc; rs1_data_i = a; rs2_data_i = b;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_%s: in_ready stayed 0, required 1", nm);
    end
    $display("txn %-8s instr=%h pc=%h rs1=%h rs2=%h", nm, ins, pc, a, b);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t stream[20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    stream[0]  = '{32'h002081B3, 32'd7, 32'd9};          // add
    stream[1]  = '{32'h002091B3, 32'h1, 32'd31};         // sll
    stream[2]  = '{32'h0020A1B3, 32'hFFFFFFFF, 32'd1};   // slt
    stream[3]  = '{32'h0020B1B3, 32'hFFFFFFFF, 32'd1};   // sltu
    stream[4]  = '{32'h0020C1B3, 32'hF0F0F0F0, 32'hFF};  // xor
    stream[5]  = '{32'h0020D1B3, 32'h80000000, 32'd3};   // srl
    stream[6]  = '{32'h4020D1B3, 32'h80000000, 32'd3};   // sra
    stream[7]  = '{32'h0020E1B3, 32'h0F, 32'hF0};        // or
    stream[8]  = '{32'h0020F1B3, 32'h0F, 32'hFF};        // and
    stream[9]  = '{32'h01F09193, 32'h1, 32'h0};          // slli 31
    stream[10] = '{32'hFFF0C193, 32'h5, 32'h0};          // xori -1
    stream[11] = '{32'h0010B193, 32'h0, 32'h0};          // sltiu 1
    stream[12] = '{32'hFFF10093, 32'h20, 32'h0};         // addi -1
    stream[13] = '{32'h0080A203, 32'h100, 32'h0};        // lw
    stream[14] = '{32'h00208463, 32'h5, 32'h5};          // beq
    stream[15] = '{32'h0020C463, 32'h5, 32'h6};          // blt
    stream[16] = '{32'h0020F463, 32'h5, 32'h6};          // bgeu
    stream[17] = '{32'h000100E7, 32'h300, 32'h0};        // jalr
    stream[18] = '{32'h00001197, 32'h0, 32'h0};          // auipc
    stream[19] = '{32'h00000013, 32'h1, 32'h2};          // nop to x0

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_oprnd2", oprnd2_o, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("rst_rd_wen", 32'(rd_wen_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    send(32'h40208133, 32'h1000, 32'd10, 32'd3, "sub");
    @(negedge clk_i);
    chk("sub_valid", 32'(out_valid_o), 32'd1);
    chk("sub_op1", oprnd1_o, 32'd10);
    chk("sub_op2", oprnd2_o, 32'd3);
    chk("sub_alu", 32'(alu_ctrl_o), 32'b0001);
    chk("sub_rd", 32'(rd_addr_o), 32'd2);
    chk("sub_wen", 32'(rd_wen_o), 32'd1);

    send(32'h40435293, 32'h1004, 32'h80000000, 32'd0, "srai");
    @(negedge clk_i);
    chk("srai_alu", 32'(alu_ctrl_o), 32'b1011);
    chk("srai_op2", oprnd2_o, 32'd4);
    chk("srai_rd", 32'(rd_addr_o), 32'd5);

    send(32'h123450B7, 32'h1008, 32'hDEAD, 32'hBEEF, "lui");
    @(negedge clk_i);
    chk("lui_op1", oprnd1_o, 32'd0);
    chk("lui_op2", oprnd2_o, 32'h12345000);
    chk("lui_alu", 32'(alu_ctrl_o), 32'd0);
    chk("lui_wen", 32'(rd_wen_o), 32'd1);

    send(32'hFE512E23, 32'h100C, 32'h200, 32'hCAFE, "sw");
    @(negedge clk_i);
    chk("sw_op2", oprnd2_o, 32'hFFFFFFFC);
    chk("sw_mem_wr", 32'(mem_wr_o), 32'd1);
    chk("sw_wen", 32'(rd_wen_o), 32'd0);
    chk("sw_store_data", store_data_o, 32'hCAFE);

    send(32'h40008193, 32'h1010, 32'd1, 32'd0, "addi400");
    @(negedge clk_i);
    chk("addi_bit30_alu", 32'(alu_ctrl_o), 32'd0);
    chk("addi_bit30_op2", oprnd2_o, 32'h400);

    send(32'h008000EF, 32'h2000, 32'd0, 32'd0, "jal");
    @(negedge clk_i);
    chk("jal_op1", oprnd1_o, 32'h2000);
    chk("jal_op2", oprnd2_o, 32'd4);
    chk("jal_jump", 32'(jump_o), 32'd1);

    send(32'h00000013, 32'h2004, 32'd1, 32'd2, "nop_x0");
    @(negedge clk_i);
    chk("x0_wen", 32'(rd_wen_o), 32'd0);

    // Back-to-back stream, checked by the model every cycle.
    for (int i = 0; i < 20; i++)
      send(stream[i].ins, 32'h3000 + 32'(4 * i), stream[i].a, stream[i].b, "stream");
    repeat (2) @(posedge clk_i);
    #1;

    // Stall with a second instruction waiting.
    send(32'h002081B3, 32'h4000, 32'h111, 32'd1, "stallA");
    out_ready_i = 1'b0;
    instr_i = 32'h002081B3; rs1_data_i = 32'h222; rs2_data_i = 32'd2; in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
      chk("stall_op1_hold", oprnd1_o, 32'h111);
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("unstall_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    $display("txn %-8s instr=%h pc=%h rs1=%h rs2=%h", "stallB", instr_i, pc_i, rs1_data_i, rs2_data_i);
    @(negedge clk_i);
    chk("unstall_valid", 32'(out_valid_o), 32'd1);
    chk("unstall_op1", oprnd1_o, 32'h222);

    // Flush with full buffer and a valid input.
    send(32'h002081B3, 32'h5000, 32'h333, 32'd1, "flushA");
    out_ready_i = 1'b0;
    instr_i = 32'h002081B3; rs1_data_i = 32'h444; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    $display("txn %-8s instr=%h flushed", "flushB", instr_i);
    @(negedge clk_i);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;

    // Asynchronous reset in the middle of a stall.
    send(32'h002081B3, 32'h6000, 32'h555, 32'd1, "rstA");
    out_ready_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("async_rst_op1", oprnd1_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    out_ready_i = 1'b1;

    // Illegal instructions: unknown opcode, then BRANCH funct3 010.
    send(32'h0000007F, 32'h7000, 32'd1, 32'd2, "ill_op");
    @(negedge clk_i);
`ifdef ILLEGAL_INSTR_TRAP_EN
    chk("ill_valid", 32'(out_valid_o), 32'd1);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_wen", 32'(rd_wen_o), 32'd0);
`else
    chk("ill_valid", 32'(out_valid_o), 32'd0);
`endif
    send(32'h0020A463, 32'h7004, 32'd1, 32'd2, "ill_br");
    @(negedge clk_i);
`ifdef ILLEGAL_INSTR_TRAP_EN
    chk("ill_br_flag", 32'(illegal_o), 32'd1);
    chk("ill_br_branch", 32'(branch_o), 32'd0);
`else
    chk("ill_br_valid", 32'(out_valid_o), 32'd0);
`endif
    // Illegal arriving while the buffer transfers.
    send(32'h002081B3, 32'h7008, 32'h666, 32'd1, "pre_ill");
    send(32'h0000007F, 32'h700C, 32'd0, 32'd0, "ill_xfer");
    @(negedge clk_i);
`ifdef ILLEGAL_INSTR_TRAP_EN
    chk("ill_xfer_valid", 32'(out_valid_o), 32'd1);
`else
    chk("ill_xfer_valid", 32'(out_valid_o), 32'd0);
`endif
    repeat (3) @(posedge clk_i);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
